// File: rtl/instr_fetch_if.sv
// Fetch-to-ROM and fetch-to-decode signal bundle.
interface instr_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic        halted;

  // fetch unit side
  modport master (
    output rom_addr, instr_valid, instr, pc_out, pc_plus4, misalign_err, halted,
    input  rom_data, instr_ready, redirect_valid, redirect_target
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  rom_addr, instr_valid, instr, pc_out, pc_plus4, misalign_err, halted,
    output rom_data, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC + fetch stage: drives ROM address, registers the returned word and
// hands it to decode over valid/ready; handles redirect flush and halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 62
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  localparam logic [31:0] LAST_PC = 32'((ROM_DEPTH - 1) * 4);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_out_q,   pc_out_d;
  logic        valid_q,    valid_d;
  logic        misalign_q, misalign_d;
  logic        halted_q,   halted_d;

  logic past_end, advance;

  assign past_end = (pc_q > LAST_PC);
  assign advance  = (state_q == RUN) && !past_end && (!valid_q || bus.instr_ready);

  // Next-state: redirect beats everything, then fetch/stall/drain, then halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;
    if (bus.redirect_valid) begin
      // flush: the in-flight word is dropped even if decode takes it now
      pc_d       = {bus.redirect_target[31:2], 2'b00};
      valid_d    = 1'b0;
      misalign_d = |bus.redirect_target[1:0];
      state_d    = RUN;
      halted_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (advance) begin
        instr_d  = bus.rom_data;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
      end else if (valid_q && bus.instr_ready) begin
        valid_d = 1'b0;
      end
      // stop only once the last delivered instruction has been consumed
      if (past_end && !valid_q) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rom_addr     = pc_q;
  assign bus.instr        = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.pc_plus4     = pc_out_q + 32'd4;
  assign bus.instr_valid  = valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.halted       = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: dut_a (62-word ROM) covers fetch/stall/redirect/reset,
// dut_b (4-word ROM) covers end-of-image halt and restart.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  instr_fetch_if ifa();
  instr_fetch_if ifb();

  instr_fetch_unit #(.RESET_PC(32'h0), .ROM_DEPTH(62)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  instr_fetch_unit #(.RESET_PC(32'h0), .ROM_DEPTH(4))  dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  // ROM image: add/sub/and/or, then distinct filler words
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    case (idx)
      30'd0:   rom_word = 32'h0011_0233;
      30'd1:   rom_word = 32'h4011_02B3;
      30'd2:   rom_word = 32'h0011_7333;
      30'd3:   rom_word = 32'h0011_63B3;
      default: rom_word = {idx[19:0], 12'h093};
    endcase
  endfunction

  assign ifa.rom_data = rom_word(ifa.rom_addr);
  assign ifb.rom_data = rom_word(ifb.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e; e.pc = pc; e.ins = ins; qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e; e.pc = pc; e.ins = ins; qb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_a();
    chk("rst_valid",    {31'b0, ifa.instr_valid},  32'h0);
    chk("rst_instr",    ifa.instr,                 32'h0000_0013);
    chk("rst_pc_out",   ifa.pc_out,                32'h0);
    chk("rst_pc_plus4", ifa.pc_plus4,              32'h4);
    chk("rst_rom_addr", ifa.rom_addr,              32'h0);
    chk("rst_misalign", {31'b0, ifa.misalign_err}, 32'h0);
    chk("rst_halted",   {31'b0, ifa.halted},       32'h0);
  endtask

  // Monitors: compare every handshake against the scoreboard head
  always @(negedge clk) begin
    if (rst_a && ifa.instr_valid && ifa.instr_ready && !ifa.redirect_valid) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected: pc_out %h with no expected entry", ifa.pc_out);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_pc_out",   ifa.pc_out,   e.pc);
        chk("a_instr",    ifa.instr,    e.ins);
        chk("a_pc_plus4", ifa.pc_plus4, e.pc + 32'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b && ifb.instr_valid && ifb.instr_ready && !ifb.redirect_valid) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected: pc_out %h with no expected entry", ifb.pc_out);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_pc_out", ifb.pc_out, e.pc);
        chk("b_instr",  ifb.instr,  e.ins);
      end
    end
  end

  task automatic wait_halt_b(input string name);
    int n;
    n = 0;
    while (!ifb.halted && n < 40) begin step(); n++; end
    chk(name, {31'b0, ifb.halted}, 32'h1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.instr_ready = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_target = '0;
    ifb.instr_ready = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_target = '0;
    repeat (2) step();
    chk_reset_a();

    // sequential fetch with decode ready
    push_a(32'h0, 32'h0011_0233);
    push_a(32'h4, 32'h4011_02B3);
    rst_a = 1'b1; ifa.instr_ready = 1'b1;
    step();
    chk("first_valid", {31'b0, ifa.instr_valid}, 32'h1);
    chk("first_pc",    ifa.pc_out, 32'h0);
    step();
    // stall with pc_out=4
    ifa.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc_out", ifa.pc_out,   32'h4);
      chk("stall_instr",  ifa.instr,    32'h4011_02B3);
      chk("stall_rom",    ifa.rom_addr, 32'h8);
      step();
    end
    push_a(32'h8, 32'h0011_7333);
    ifa.instr_ready = 1'b1;
    step();
    chk("after_stall_pc", ifa.pc_out, 32'h8);
    step();
    // pc_out=12 held, aligned redirect flushes it
    ifa.instr_ready = 1'b0;
    ifa.redirect_valid = 1'b1; ifa.redirect_target = 32'h10;
    step();
    ifa.redirect_valid = 1'b0;
    chk("redir_valid",    {31'b0, ifa.instr_valid},  32'h0);
    chk("redir_rom",      ifa.rom_addr,              32'h10);
    chk("redir_misalign", {31'b0, ifa.misalign_err}, 32'h0);
    step();
    chk("redir_pc_out",    ifa.pc_out, 32'h10);
    chk("redir_valid2",    {31'b0, ifa.instr_valid},  32'h1);
    chk("redir_misalign2", {31'b0, ifa.misalign_err}, 32'h0);
    push_a(32'h10, rom_word(32'h10));
    ifa.instr_ready = 1'b1;
    step();
    // misaligned redirect
    ifa.instr_ready = 1'b0;
    ifa.redirect_valid = 1'b1; ifa.redirect_target = 32'h22;
    step();
    ifa.redirect_valid = 1'b0;
    chk("mis_rom",   ifa.rom_addr,              32'h20);
    chk("mis_pulse", {31'b0, ifa.misalign_err}, 32'h1);
    chk("mis_valid", {31'b0, ifa.instr_valid},  32'h0);
    step();
    chk("mis_clear",  {31'b0, ifa.misalign_err}, 32'h0);
    chk("mis_pc_out", ifa.pc_out, 32'h20);
    push_a(32'h20, rom_word(32'h20));
    ifa.instr_ready = 1'b1;
    step();
    // reset during stall with a redirect pending
    ifa.instr_ready = 1'b0;
    ifa.redirect_valid = 1'b1; ifa.redirect_target = 32'h40;
    rst_a = 1'b0;
    step();
    chk_reset_a();
    ifa.redirect_valid = 1'b0;
    chk("a_queue_drained", qa.size(), 32'h0);

    // dut_b: run off the end of a 4-word image
    for (int i = 0; i < 4; i++) push_b(32'(i * 4), rom_word(32'(i * 4)));
    rst_b = 1'b1; ifb.instr_ready = 1'b1;
    wait_halt_b("b_halt");
    chk("b_halt_valid", {31'b0, ifb.instr_valid}, 32'h0);
    chk("b_halt_rom",   ifb.rom_addr, 32'h10);
    chk("b_drained",    qb.size(), 32'h0);
    step();
    chk("b_pc_holds", ifb.rom_addr, 32'h10);
    // restart at 0
    for (int i = 0; i < 4; i++) push_b(32'(i * 4), rom_word(32'(i * 4)));
    ifb.redirect_valid = 1'b1; ifb.redirect_target = 32'h0;
    step();
    ifb.redirect_valid = 1'b0;
    chk("b_unhalt",  {31'b0, ifb.halted}, 32'h0);
    chk("b_restart", ifb.rom_addr, 32'h0);
    step();
    chk("b_resume_pc", ifb.pc_out, 32'h0);
    wait_halt_b("b_rehalt");
    chk("b_drained2", qb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
